sd_cmd_master: RTL

Command-path controller that sequences `sd_cmd_serial_host`. It accepts a command request (index, argument, response type, check enables, timeout) from the register layer and assembles the 40-bit command frame. It launches the serial host with a one-cycle start pulse, then waits for completion or timeout, latches the response and reports sticky interrupt status. It sits between the Wishbone register bank and the serial host, in the `sd_clk` domain.

---
 rtl/sd_cmd_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sd_cmd_master.sv
// Command-path controller for the SD serial host: builds the 40-bit command frame,
// launches the serial host, waits for completion or timeout and keeps sticky status.
module sd_cmd_master #(
  parameter int INIT_CYCLES = 66,
  parameter int TO_W        = 16
) (
  input  logic              sd_clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [5:0]        cmd_index_i,
  input  logic [31:0]       argument_i,
  input  logic [1:0]        resp_type_i,
  input  logic              crc_check_i,
  input  logic              idx_check_i,
  input  logic [TO_W-1:0]   timeout_i,
  input  logic              int_status_rst_i,
  input  logic              finish_i,
  input  logic              crc_ok_i,
  input  logic              index_ok_i,
  input  logic [119:0]      response_i,
  output logic              start_xfr_o,
  output logic [39:0]       cmd_o,
  output logic [1:0]        setting_o,
  output logic [119:0]      response_o,
  output logic [4:0]        int_status_o,
  output logic              busy_o
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_EXECUTE
  } state_t;

  state_t            state_reg;
  logic [INIT_W-1:0] init_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic [TO_W-1:0]   timeout_reg;
  logic [1:0]        resp_type_reg;
  logic              crc_check_reg;
  logic              idx_check_reg;

  logic [TO_W-1:0]   to_cnt_next;
  logic [1:0]        resp_type_norm;
  logic [4:0]        status_base;
  logic [4:0]        finish_bits;
  logic              resp_present;
  logic              resp_short;
  logic              crc_err;
  logic              idx_err;
  logic              to_hit;

  always_comb begin
    // Type 2 is an alias for a short response, both towards the host and for the checks.
    resp_type_norm = (resp_type_i == 2'd2) ? 2'd1 : resp_type_i;
    resp_present   = (resp_type_reg != 2'd0);
    resp_short     = (resp_type_reg == 2'd1);
    crc_err        = crc_check_reg && resp_present && !crc_ok_i;
    idx_err        = idx_check_reg && resp_short && !index_ok_i;
    finish_bits    = {idx_err, crc_err, 1'b0, crc_err | idx_err, 1'b1};
    // Saturating count: the timer never wraps back into a false match.
    to_cnt_next    = (to_cnt_reg == '1) ? to_cnt_reg : to_cnt_reg + TO_W'(1);
    to_hit         = (timeout_reg != '0) && (to_cnt_next == timeout_reg);
    // A clear request is applied first so that a same-cycle set survives it.
    status_base    = int_status_rst_i ? 5'd0 : int_status_o;
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      timeout_reg   <= '0;
      resp_type_reg <= 2'd0;
      crc_check_reg <= 1'b0;
      idx_check_reg <= 1'b0;
      start_xfr_o   <= 1'b0;
      cmd_o         <= '0;
      setting_o     <= 2'd0;
      response_o    <= '0;
      int_status_o  <= 5'd0;
      busy_o        <= 1'b1;
    end else begin
      start_xfr_o  <= 1'b0;
      int_status_o <= status_base;
      case (state_reg)
        ST_INIT: begin
          if (init_cnt_reg == INIT_LAST) begin
            state_reg <= ST_IDLE;
            busy_o    <= 1'b0;
          end else begin
            init_cnt_reg <= init_cnt_reg + INIT_W'(1);
          end
        end
        ST_IDLE: begin
          if (start_i) begin
            resp_type_reg <= resp_type_norm;
            crc_check_reg <= crc_check_i;
            idx_check_reg <= idx_check_i;
            timeout_reg   <= timeout_i;
            cmd_o         <= {2'b01, cmd_index_i, argument_i};
            setting_o     <= resp_type_norm;
            start_xfr_o   <= 1'b1;
            busy_o        <= 1'b1;
            to_cnt_reg    <= '0;
            state_reg     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          to_cnt_reg <= '0;
          state_reg  <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          // Completion has priority over a timeout landing on the same edge.
          if (finish_i) begin
            int_status_o <= status_base | finish_bits;
            if (resp_present) begin
              response_o <= response_i;
            end
            busy_o    <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (to_hit) begin
            int_status_o <= status_base | 5'b00111;
            busy_o       <= 1'b0;
            state_reg    <= ST_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_next;
          end
        end
        default: begin
          state_reg <= ST_INIT;
        end
      endcase
    end
  end

endmodule
